// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the pipeline requesters and the regFile write port.
// Latency: none. The interface only carries signals.
// Backpressure: req_ready from the arbiter stalls each requester's valid/addr/data.
//
// Ports (signals):
//   req_valid/req_ready     per-requester handshake, one bit per requester
//   req_addr/req_data       packed per-requester destination register and data
//   regWriteEn/Addr/Data    registered regFile write port driven by the arbiter
interface reg_wb_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    regWriteEn;
    logic [ADDR_W-1:0]       regWriteAddr;
    logic [DATA_W-1:0]       regWriteData;

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, regWriteEn, regWriteAddr, regWriteData
    );

    // Requester / regFile side
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, regWriteEn, regWriteAddr, regWriteData
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin owner of the regFile write port, with a 31..1 init sweep.
// Latency: 1 cycle from a valid/ready transfer to the regFile write.
// Backpressure: one combinational ready per cycle. All ready bits are low during the sweep, in reset, and while init_start is asserted.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   wb (slave)      requester handshake in, registered regFile write port out
//   init_start      1-cycle pulse that starts the sweep (ignored while sweeping)
//   init_busy       high while the sweep runs
//   init_done       pulse coincident with the final (addr 1) sweep write
//   grant_id        index of the requester whose transfer produced the last write
module reg_wb_arbiter #(
    parameter int                N_REQ      = 3,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] INIT_VALUE = 32'h55aaaa55
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_wb_arbiter_if.slave        wb,
    input  logic                   init_start,
    output logic                   init_busy,
    output logic                   init_done,
    output logic [2:0]             grant_id
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } state_e;

    localparam logic [3:0] N_REQ_L = 4'(N_REQ);

    state_e              state_q, state_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          gid_q, gid_d;
    logic                done_q, done_d;

    logic [N_REQ-1:0]    valid_rot;
    logic                gnt_vld;
    logic [3:0]          idx_sum;
    logic [2:0]          gnt_idx;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;
    logic                arb_ok;
    logic [N_REQ-1:0]    ready_c;
    logic                xfer;

    // Rotate valids so bit 0 is the requester at rr_ptr. The lowest set
    // bit of the rotated vector is then the round-robin winner.
    always_comb begin
        valid_rot = N_REQ'({wb.req_valid, wb.req_valid} >> rr_ptr_q);
        gnt_vld   = 1'b0;
        idx_sum   = '0;
        // Descending scan: the last hit written is the lowest offset.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                gnt_vld = 1'b1;
                idx_sum = {1'b0, rr_ptr_q} + 4'(k);
            end
        end
        if (idx_sum >= N_REQ_L) begin
            idx_sum = idx_sum - N_REQ_L;
        end
        gnt_idx = idx_sum[2:0];
    end

    // Winner's address/data, and the one-hot ready
    always_comb begin
        arb_ok   = (state_q == ST_RUN) && !init_start && !reset;
        gnt_addr = '0;
        gnt_data = '0;
        ready_c  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == 3'(i)) begin
                gnt_addr   = wb.req_addr[i*ADDR_W +: ADDR_W];
                gnt_data   = wb.req_data[i*DATA_W +: DATA_W];
                ready_c[i] = arb_ok && gnt_vld;
            end
        end
        xfer = |(wb.req_valid & ready_c);
    end

    // Next-state and registered write-port values
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        gid_d    = gid_q;
        done_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (init_start) begin
                    state_d = ST_INIT;
                    cnt_d   = 5'd31;
                end else if (xfer) begin
                    // Writes to $0 complete the handshake but never reach the regFile.
                    wen_d    = (gnt_addr != '0);
                    waddr_d  = gnt_addr;
                    wdata_d  = gnt_data;
                    gid_d    = gnt_idx;
                    rr_ptr_d = (gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
                end
            end
            ST_INIT: begin
                wen_d   = 1'b1;
                waddr_d = ADDR_W'(cnt_q);
                wdata_d = INIT_VALUE;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            gid_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            gid_q    <= gid_d;
            done_q   <= done_d;
        end
    end

    assign wb.req_ready    = ready_c;
    assign wb.regWriteEn   = wen_q;
    assign wb.regWriteAddr = waddr_q;
    assign wb.regWriteData = wdata_q;
    assign init_busy       = (state_q == ST_INIT);
    assign init_done       = done_q;
    assign grant_id        = gid_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
    localparam int          N_REQ  = 3;
    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 5;
    localparam logic [31:0] INIT_V = 32'h55aaaa55;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_start;
    logic       init_busy;
    logic       init_done;
    logic [2:0] grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side view
    logic [N_REQ-1:0]  rv;
    logic [ADDR_W-1:0] ra [N_REQ];
    logic [DATA_W-1:0] rd [N_REQ];

    reg_wb_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_wb_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VALUE(INIT_V)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (bus),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic drive();
        bus.req_valid = rv;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_addr[i*ADDR_W +: ADDR_W] = ra[i];
            bus.req_data[i*DATA_W +: DATA_W] = rd[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; init_start = 1'b0; rv = '0;
        drive();
        tick(); tick();
        reset = 1'b0;
    endtask

    // Reference round-robin choice: first valid index at or after ptr, wrapping.
    function automatic int model_pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int j = 0; j < N_REQ; j++) begin
            if (v[(ptr + j) % N_REQ]) return (ptr + j) % N_REQ;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; init_start = 1'b0; rv = 3'b111;
        for (int i = 0; i < N_REQ; i++) begin ra[i] = 5'(i + 1); rd[i] = 32'(i + 100); end
        drive(); settle();
        n_tests++;
        if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready0: got %b want 000", bus.req_ready); end
        tick(); tick();
        n_tests++;
        if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready1: got %b want 000", bus.req_ready); end
        n_tests++;
        if ({bus.regWriteEn, grant_id, init_busy, init_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: wen=%b gid=%0d busy=%b done=%b want all 0",
                     bus.regWriteEn, grant_id, init_busy, init_done);
        end
        reset = 1'b0; rv = '0; drive();
    endtask

    task automatic test_single_write();
        do_reset();
        rv = 3'b001; ra[0] = 5'd5; rd[0] = 32'h12345678;
        drive(); settle();
        n_tests++;
        if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b want 001", bus.req_ready); end
        tick();
        rv = '0; drive();
        n_tests++;
        if ({bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id} !== {1'b1, 5'd5, 32'h12345678, 3'd0}) begin
            n_fail++;
            $display("FAIL single_write: got en=%b a=%0d d=%h g=%0d want en=1 a=5 d=12345678 g=0",
                     bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id);
        end
        tick();
        n_tests++;
        if (bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL single_idle: en=%b want 0", bus.regWriteEn); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rv = 3'b111;
        for (int i = 0; i < N_REQ; i++) begin ra[i] = 5'(10 + i); rd[i] = 32'hc0de0000 + 32'(i); end
        drive();
        for (int c = 0; c < 6; c++) begin
            int e;
            logic [2:0] er;
            e = c % N_REQ;
            er = 3'(1 << e);
            settle();
            n_tests++;
            if (bus.req_ready !== er) begin n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, bus.req_ready, er); end
            tick();
            n_tests++;
            if ({bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id} !== {1'b1, ra[e], rd[e], 3'(e)}) begin
                n_fail++;
                $display("FAIL rr_write c%0d: got en=%b a=%0d g=%0d want en=1 a=%0d g=%0d",
                         c, bus.regWriteEn, bus.regWriteAddr, grant_id, ra[e], e);
            end
        end
        rv = '0; drive();
    endtask

    task automatic test_zero_addr();
        do_reset();
        rv = 3'b010; ra[1] = 5'd0; rd[1] = 32'hdeadbeef;
        drive(); settle();
        n_tests++;
        if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL zero_ready: got %b want 010", bus.req_ready); end
        tick();
        rv = 3'b100; ra[2] = 5'd7; rd[2] = 32'h0badf00d;
        drive();
        n_tests++;
        if ({bus.regWriteEn, grant_id} !== {1'b0, 3'd1}) begin
            n_fail++; $display("FAIL zero_nowrite: got en=%b g=%0d want en=0 g=1", bus.regWriteEn, grant_id);
        end
        settle();
        n_tests++;
        if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL zero_next_ready: got %b want 100", bus.req_ready); end
        tick();
        rv = '0; drive();
        n_tests++;
        if ({bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id} !== {1'b1, 5'd7, 32'h0badf00d, 3'd2}) begin
            n_fail++;
            $display("FAIL zero_next_write: got en=%b a=%0d d=%h g=%0d want en=1 a=7 d=0badf00d g=2",
                     bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id);
        end
    endtask

    task automatic test_init_sweep();
        do_reset();
        rv = 3'b001; ra[0] = 5'd3; rd[0] = 32'ha5a50003;
        init_start = 1'b1;
        drive(); settle();
        n_tests++;
        if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL init_start_ready: got %b want 000", bus.req_ready); end
        tick();
        init_start = 1'b0;
        n_tests++;
        if ({init_busy, bus.regWriteEn} !== 2'b10) begin
            n_fail++; $display("FAIL init_e0: busy=%b en=%b want busy=1 en=0", init_busy, bus.regWriteEn);
        end
        for (int k = 1; k <= 31; k++) begin
            logic [4:0] ea;
            ea = 5'(32 - k);
            init_start = (k == 10);
            settle();
            n_tests++;
            if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL init_ready k%0d: got %b want 000", k, bus.req_ready); end
            tick();
            n_tests++;
            if ({bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, init_done} !== {1'b1, ea, INIT_V, (k == 31)}) begin
                n_fail++;
                $display("FAIL init_write k%0d: got en=%b a=%0d d=%h done=%b want en=1 a=%0d d=%h done=%b",
                         k, bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, init_done, ea, INIT_V, (k == 31));
            end
        end
        init_start = 1'b0;
        n_tests++;
        if (init_busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_end: got %b want 0", init_busy); end
        settle();
        n_tests++;
        if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL init_resume_ready: got %b want 001", bus.req_ready); end
        tick();
        rv = '0; drive();
        n_tests++;
        if ({bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id, init_done} !== {1'b1, 5'd3, 32'ha5a50003, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL init_resume_write: got en=%b a=%0d d=%h g=%0d done=%b want en=1 a=3 d=a5a50003 g=0 done=0",
                     bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id, init_done);
        end
    endtask

    task automatic test_reset_mid_init();
        bit found;
        bit saw_bad;
        do_reset();
        init_start = 1'b1; drive();
        tick();
        init_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (bus.regWriteEn === 1'b1 && bus.regWriteAddr === 5'd20) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL midinit_wait: addr 20 write not seen in 40 cycles (got found=%b want 1)", found);
        end else begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            n_tests++;
            if ({bus.regWriteEn, init_busy, init_done} !== 3'b000) begin
                n_fail++; $display("FAIL midinit_abort: en=%b busy=%b done=%b want 000", bus.regWriteEn, init_busy, init_done);
            end
            saw_bad = 1'b0;
            for (int c = 0; c < 35; c++) begin
                tick();
                if (init_done !== 1'b0 || bus.regWriteEn !== 1'b0 || init_busy !== 1'b0) saw_bad = 1'b1;
            end
            n_tests++;
            if (saw_bad !== 1'b0) begin n_fail++; $display("FAIL midinit_quiet: activity after abort got %b want 0", saw_bad); end
            init_start = 1'b1;
            tick();
            init_start = 1'b0;
            tick();
            n_tests++;
            if ({bus.regWriteEn, bus.regWriteAddr, init_busy} !== {1'b1, 5'd31, 1'b1}) begin
                n_fail++;
                $display("FAIL midinit_restart: en=%b a=%0d busy=%b want en=1 a=31 busy=1",
                         bus.regWriteEn, bus.regWriteAddr, init_busy);
            end
        end
    endtask

    task automatic test_random();
        int         ptr;
        int         g;
        logic [2:0] exp_rdy;
        logic       exp_wen;
        logic [4:0] exp_addr;
        logic [31:0] exp_data;
        logic [2:0] exp_gid;
        do_reset();
        ptr = 0; exp_wen = 1'b0; exp_addr = '0; exp_data = '0; exp_gid = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rv[i]) begin
                    if ($urandom_range(0, 15) == 0) rv[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    ra[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    rd[i] = $urandom;
                end
            end
            drive(); settle();
            g = model_pick(rv, ptr);
            exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
            n_tests++;
            if (bus.req_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, bus.req_ready, exp_rdy);
            end
            tick();
            if (g >= 0) begin
                exp_wen  = (ra[g] != 5'd0);
                exp_addr = ra[g];
                exp_data = rd[g];
                exp_gid  = 3'(g);
                ptr      = (g + 1) % N_REQ;
                rv[g]    = 1'b0;
            end else begin
                exp_wen = 1'b0;
            end
            n_tests++;
            if ({bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id} !== {exp_wen, exp_addr, exp_data, exp_gid}) begin
                n_fail++;
                $display("FAIL rand_write cyc%0d: got en=%b a=%0d d=%h g=%0d want en=%b a=%0d d=%h g=%0d",
                         cyc, bus.regWriteEn, bus.regWriteAddr, bus.regWriteData, grant_id,
                         exp_wen, exp_addr, exp_data, exp_gid);
            end
        end
        rv = '0; drive();
    endtask

    initial begin
        reset = 1'b1; init_start = 1'b0; rv = '0;
        for (int i = 0; i < N_REQ; i++) begin ra[i] = '0; rd[i] = '0; end
        drive();
        #2;
        test_reset();
        test_single_write();
        test_round_robin();
        test_zero_addr();
        test_init_sweep();
        test_reset_mid_init();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
